// File: rtl/blk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : blk_pkg
//  Description : Definitions shared by the block-decision buffer blocks:
//                the vertical sequencer state encoding and the default
//                frame/block geometry. The horizontal buffer uses the
//                KH/HP values and the vertical sequencer uses KV/VP.
//  Revision    : 1.0 - initial release
// ============================================================================
package blk_pkg;

    // Default geometry (1080p frame, 8x10 pixel blocks)
    localparam int c_DEF_HP = 1920;  // active pixels per line
    localparam int c_DEF_KH = 8;     // pixels per block column
    localparam int c_DEF_VP = 1080;  // active lines per frame
    localparam int c_DEF_KV = 10;    // lines per block row

    // Vertical sequencer states, explicitly encoded on 2 bits
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,  // after reset, waiting for the first vs
        ST_VBLANK = 2'd1,  // vertical blanking, counters cleared
        ST_ACTIVE = 2'd2,  // counting lines of the current block row
        ST_COMMIT = 2'd3   // freeze held until the buffer sees an hs rise
    } seq_state_e;

endpackage : blk_pkg
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge
//  Description : Registers one sync/enable input and provides single-cycle
//                rise and fall pulses relative to the registered level.
//  Ports       : clk_i  - pixel clock
//                rst_i  - asynchronous active-high reset
//                sig_i  - raw sync input
//                lvl_o  - sig_i delayed by one clock
//                rise_o - sig_i & ~lvl_o (combinational)
//                fall_o - ~sig_i & lvl_o (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic r_lvl;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lvl <= 1'b0;
        end else begin
            r_lvl <= sig_i;
        end
    end

    assign lvl_o  = r_lvl;
    assign rise_o = sig_i & ~r_lvl;
    assign fall_o = ~sig_i & r_lvl;

endmodule : sync_edge
`default_nettype wire

// File: rtl/blk_row_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : blk_row_sequencer
//  Description : Vertical sequencer for the block-decision buffer. Counts
//                active lines into block rows of KV lines and raises the
//                freeze commit strobe once per completed block row, held
//                until the buffer has seen exactly one hs rising edge.
//  Parameters  : VP  - active lines per frame
//                KV  - lines per block row (must be >= 2)
//                VBW - width of the block-row index
//  Ports       : clk_i       - pixel clock, rising edge
//                rst_i       - asynchronous active-high reset
//                pause_i     - hold current decisions (macro builds only)
//                vs_i/hs_i   - vertical / horizontal sync, active-high
//                de_i        - data enable
//                freeze_o    - commit request, level-held over an hs rise
//                vb_o        - index of the block row being accumulated
//                row_valid_o - decision bank holds a row of this frame
//                frame_o     - completed-frame counter (wraps)
//  Options     : BLK_ROW_SEQUENCER_PAUSE_EN adds pause_i
//  Revision    : 1.0 - initial release
// ============================================================================
module blk_row_sequencer
    import blk_pkg::*;
#(
    parameter int VP  = c_DEF_VP,
    parameter int KV  = c_DEF_KV,
    parameter int VBW = $clog2(VP / KV + 1)
) (
    input  logic           clk_i,
    input  logic           rst_i,
`ifdef BLK_ROW_SEQUENCER_PAUSE_EN
    input  logic           pause_i,
`endif
    input  logic           vs_i,
    input  logic           hs_i,
    input  logic           de_i,
    output logic           freeze_o,
    output logic [VBW-1:0] vb_o,
    output logic           row_valid_o,
    output logic [15:0]    frame_o
);

    localparam int               c_VCW    = $clog2(KV);
    localparam logic [c_VCW-1:0] c_V_LAST = c_VCW'(KV - 1);
    localparam logic [VBW-1:0]   c_VB_MAX = VBW'(VP / KV);

    // Edge detection on the raw timing inputs
    logic w_vs_lvl, w_vs_rise, w_vs_fall;
    logic w_hs_lvl, w_hs_rise, w_hs_fall;
    logic w_de_lvl, w_de_rise, w_line_end;

    sync_edge u_vs_edge (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .sig_i  (vs_i),
        .lvl_o  (w_vs_lvl),
        .rise_o (w_vs_rise),
        .fall_o (w_vs_fall)
    );

    sync_edge u_hs_edge (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .sig_i  (hs_i),
        .lvl_o  (w_hs_lvl),
        .rise_o (w_hs_rise),
        .fall_o (w_hs_fall)
    );

    sync_edge u_de_edge (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .sig_i  (de_i),
        .lvl_o  (w_de_lvl),
        .rise_o (w_de_rise),
        .fall_o (w_line_end)
    );

    logic w_unused;
    assign w_unused = &{1'b0, w_vs_lvl, w_vs_fall, w_hs_lvl, w_hs_fall,
                        w_de_lvl, w_de_rise};

    logic w_pause;
`ifdef BLK_ROW_SEQUENCER_PAUSE_EN
    assign w_pause = pause_i;
`else
    assign w_pause = 1'b0;
`endif

    seq_state_e       r_state, w_state;
    logic [c_VCW-1:0] r_v_cur, w_v_cur;
    logic [VBW-1:0]   r_vb, w_vb, w_vb_inc;
    logic             r_freeze, w_freeze;
    logic             r_row_valid, w_row_valid;
    logic [15:0]      r_frame, w_frame;

    // Block-row index saturates so lines beyond VP cannot overflow it
    assign w_vb_inc = (r_vb == c_VB_MAX) ? r_vb : r_vb + VBW'(1);

    always_comb begin
        w_state     = r_state;
        w_v_cur     = r_v_cur;
        w_vb        = r_vb;
        w_freeze    = r_freeze;
        w_row_valid = r_row_valid;
        w_frame     = r_frame;

        if ((r_state == ST_ACTIVE || r_state == ST_COMMIT) && w_vs_rise) begin
            // Frame boundary wins over everything else; a partial row
            // (or a pending commit) is dropped without touching the bank.
            w_state  = ST_VBLANK;
            w_freeze = 1'b0;
            w_v_cur  = '0;
            w_vb     = '0;
            w_frame  = r_frame + 16'd1;
            if (!w_pause) begin
                w_row_valid = 1'b0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_vs_rise) begin
                        w_state = ST_VBLANK;
                    end
                end
                ST_VBLANK: begin
                    w_v_cur = '0;
                    w_vb    = '0;
                    if (de_i) begin
                        w_state = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    // hs is deliberately not looked at here: an hs rise
                    // coincident with the closing line end must not
                    // terminate the commit it starts.
                    if (w_line_end) begin
                        if (r_v_cur == c_V_LAST) begin
                            w_v_cur = '0;
                            if (w_pause) begin
                                w_vb = w_vb_inc;
                            end else begin
                                w_freeze = 1'b1;
                                w_state  = ST_COMMIT;
                            end
                        end else begin
                            w_v_cur = r_v_cur + c_VCW'(1);
                        end
                    end
                end
                ST_COMMIT: begin
                    // A line end here is a sync violation; still count it
                    // but keep the counter inside its range.
                    if (w_line_end && r_v_cur != c_V_LAST) begin
                        w_v_cur = r_v_cur + c_VCW'(1);
                    end
                    if (w_hs_rise) begin
                        w_freeze    = 1'b0;
                        w_vb        = w_vb_inc;
                        w_row_valid = 1'b1;
                        w_state     = ST_ACTIVE;
                    end
                end
                default: begin
                    w_state = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_v_cur     <= '0;
            r_vb        <= '0;
            r_freeze    <= 1'b0;
            r_row_valid <= 1'b0;
            r_frame     <= 16'd0;
        end else begin
            r_state     <= w_state;
            r_v_cur     <= w_v_cur;
            r_vb        <= w_vb;
            r_freeze    <= w_freeze;
            r_row_valid <= w_row_valid;
            r_frame     <= w_frame;
        end
    end

    assign freeze_o    = r_freeze;
    assign vb_o        = r_vb;
    assign row_valid_o = r_row_valid;
    assign frame_o     = r_frame;

endmodule : blk_row_sequencer
`default_nettype wire

// File: tb/tb_blk_row_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_blk_row_sequencer
//  Description : Scoreboard bench for blk_row_sequencer with VP=40, KV=10.
//                Stimulus tasks push the expected freeze rise / freeze fall
//                / frame events; a monitor pops and compares them whenever
//                the DUT presents one. Pause scenario is built only when
//                BLK_ROW_SEQUENCER_PAUSE_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_blk_row_sequencer;

    localparam int VP  = 40;
    localparam int KV  = 10;
    localparam int VBW = $clog2(VP / KV + 1);

    localparam int K_RISE  = 0;
    localparam int K_FALL  = 1;
    localparam int K_FRAME = 2;

    logic           clk   = 1'b0;
    logic           rst_i = 1'b0;
    logic           vs_i  = 1'b0;
    logic           hs_i  = 1'b0;
    logic           de_i  = 1'b0;
    logic           freeze_o;
    logic [VBW-1:0] vb_o;
    logic           row_valid_o;
    logic [15:0]    frame_o;
    bit             pause_now = 1'b0;

`ifdef BLK_ROW_SEQUENCER_PAUSE_EN
    logic pause_i;
    assign pause_i = pause_now;
`endif

    always #5 clk = ~clk;

    blk_row_sequencer #(
        .VP  (VP),
        .KV  (KV),
        .VBW (VBW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
`ifdef BLK_ROW_SEQUENCER_PAUSE_EN
        .pause_i     (pause_i),
`endif
        .vs_i        (vs_i),
        .hs_i        (hs_i),
        .de_i        (de_i),
        .freeze_o    (freeze_o),
        .vb_o        (vb_o),
        .row_valid_o (row_valid_o),
        .frame_o     (frame_o)
    );

    typedef struct {
        int kind;
        int vb;
        int rv;
        int frame;
        int hs;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    // Reference state: m_st 0=idle, 1=vblank, 2=active
    int m_st = 0, m_v = 0, m_vb = 0, m_rv = 0, m_frame = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input int vb, input int rv, input int fr, input int hs);
        ev_t e;
        e.kind = k; e.vb = vb; e.rv = rv; e.frame = fr; e.hs = hs;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_vs();
        if (m_st == 2) begin
            m_frame = (m_frame + 1) & 16'hFFFF;
            if (!pause_now) m_rv = 0;
            push(K_FRAME, 0, m_rv, m_frame, 0);
        end
        m_st = 1;
        m_v  = 0;
        m_vb = 0;
    endtask

    task automatic model_line_end();
        int nvb;
        if (m_st == 2) begin
            if (m_v == KV - 1) begin
                m_v = 0;
                nvb = (m_vb < VP / KV) ? m_vb + 1 : m_vb;
                if (!pause_now) begin
                    push(K_RISE, m_vb, m_rv, m_frame, 0);
                    push(K_FALL, nvb, 1, m_frame, 1);
                    m_rv = 1;
                end
                m_vb = nvb;
            end else begin
                m_v++;
            end
        end
    endtask

    // One line: 20 de cycles, then hs pulse. coinc puts the hs rise on the
    // line-end cycle (and adds a second hs pulse); vs_end raises vs there.
    task automatic drive_line(input bit coinc, input bit vs_end);
        if (m_st == 1) m_st = 2;
        if (vs_end) model_vs();
        else        model_line_end();
        de_i = 1'b1;
        cyc(20);
        de_i = 1'b0;
        if (coinc)  hs_i = 1'b1;
        if (vs_end) vs_i = 1'b1;
        cyc(1);
        if (vs_end) begin
            cyc(2); vs_i = 1'b0; cyc(5);
        end else if (coinc) begin
            cyc(3); hs_i = 1'b0; cyc(4);
            hs_i = 1'b1; cyc(4); hs_i = 1'b0; cyc(2);
        end else begin
            cyc(1); hs_i = 1'b1; cyc(4); hs_i = 1'b0; cyc(2);
        end
    endtask

    task automatic drive_vs();
        model_vs();
        vs_i = 1'b1; cyc(3);
        vs_i = 1'b0; cyc(5);
    endtask

    task automatic check_ev(input int kind, input int vb, input int rv, input int fr, input int hs);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind=%0d vb=%0d rv=%0d frame=%0d, expected no event (t=%0t)",
                     kind, vb, rv, fr, $time);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            if (kind == e.kind) begin
                chk(kind == K_FRAME ? "frame_vb" : (kind == K_RISE ? "rise_vb" : "fall_vb"), vb, e.vb);
                chk(kind == K_FRAME ? "frame_row_valid" : (kind == K_RISE ? "rise_row_valid" : "fall_row_valid"), rv, e.rv);
                chk(kind == K_FRAME ? "frame_count" : "freeze_frame_count", fr, e.frame);
                if (kind == K_FALL) chk("hs_rises_during_freeze", hs, e.hs);
            end
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge
    initial begin : mon
        logic p_fr, p_hs;
        logic [15:0] p_frame;
        int hs_cnt;
        p_fr = 1'b0; p_hs = 1'b0; p_frame = 16'd0; hs_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                if (freeze_o && !p_fr) hs_cnt = 0;
                if (freeze_o && hs_i && !p_hs) hs_cnt++;
                if (frame_o != p_frame)
                    check_ev(K_FRAME, int'(vb_o), int'(row_valid_o), int'(frame_o), 0);
                else if (freeze_o && !p_fr)
                    check_ev(K_RISE, int'(vb_o), int'(row_valid_o), int'(frame_o), 0);
                else if (!freeze_o && p_fr)
                    check_ev(K_FALL, int'(vb_o), int'(row_valid_o), int'(frame_o), hs_cnt);
            end else begin
                hs_cnt = 0;
            end
            p_fr    = freeze_o;
            p_hs    = hs_i;
            p_frame = frame_o;
        end
    end

    initial begin : stim
        rst_i = 1'b1;
        cyc(3);
        chk("reset_freeze", int'(freeze_o), 0);
        chk("reset_vb", int'(vb_o), 0);
        chk("reset_row_valid", int'(row_valid_o), 0);
        chk("reset_frame", int'(frame_o), 0);
        rst_i = 1'b0;
        cyc(2);

        // Two full frames: 4 commits each, frame count 1 then 2
        drive_vs();
        repeat (40) drive_line(1'b0, 1'b0);
        drive_vs();
        repeat (40) drive_line(1'b0, 1'b0);
        drive_vs();

        // Short frame of 35 lines: 3 commits, vs clears row_valid
        repeat (35) drive_line(1'b0, 1'b0);
        drive_vs();

        // vs on the same cycle as a row-closing line end: no commit
        repeat (19) drive_line(1'b0, 1'b0);
        drive_line(1'b0, 1'b1);
        chk("vb_after_vs_cut", int'(vb_o), 0);
        chk("freeze_after_vs_cut", int'(freeze_o), 0);

        // Coincident line end/hs rise on row 1, then 50 lines (vb saturates)
        repeat (9) drive_line(1'b0, 1'b0);
        drive_line(1'b1, 1'b0);
        repeat (40) drive_line(1'b0, 1'b0);
        chk("vb_saturated", int'(vb_o), VP / KV);
        drive_vs();

`ifdef BLK_ROW_SEQUENCER_PAUSE_EN
        // Pause over lines 10..29: commits only at lines 10 and 40
        for (int i = 0; i < 40; i++) begin
            pause_now = (i >= 10 && i <= 29);
            drive_line(1'b0, 1'b0);
        end
        pause_now = 1'b0;
        chk("vb_after_pause_frame", int'(vb_o), 4);
        drive_vs();
`endif

        // Reset during COMMIT
        repeat (9) drive_line(1'b0, 1'b0);
        if (m_st == 1) m_st = 2;
        model_line_end();
        de_i = 1'b1;
        cyc(20);
        de_i = 1'b0;
        cyc(1);
        #5;
        chk("freeze_in_commit", int'(freeze_o), 1);
        rst_i = 1'b1;
        #1;
        chk("freeze_async_clear", int'(freeze_o), 0);
        chk("frame_async_clear", int'(frame_o), 0);
        exp_q.delete();
        m_st = 0; m_v = 0; m_vb = 0; m_rv = 0; m_frame = 0;
        cyc(2);
        rst_i = 1'b0;
        cyc(2);
        repeat (10) drive_line(1'b0, 1'b0);
        chk("no_freeze_before_vs", int'(freeze_o), 0);
        drive_vs();
        repeat (10) drive_line(1'b0, 1'b0);
        chk("vb_after_reset_row", int'(vb_o), 1);

        cyc(5);
        chk("pending_events", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_blk_row_sequencer
`default_nettype wire
